// File: rtl/oka_pkg.sv
// Shared types, constants and helpers for the OKA sub-product engine.
// Optional build macro OKA_ZERO_SKIP_EN is consumed by oka_subproduct_engine_16bit.
package oka_pkg;

    localparam int unsigned OKA_N  = 16;
    localparam int unsigned OKA_H  = OKA_N / 2;
    localparam int unsigned OKA_PW = 2 * OKA_H - 1;
    localparam int unsigned OKA_SW = $clog2(OKA_H);

    typedef logic [OKA_H-1:0]  half_t;
    typedef logic [OKA_PW-1:0] subprod_t;
    typedef logic [OKA_SW-1:0] step_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Latched operand halves: X factors from A, Y factors from B
    typedef struct packed {
        half_t ae;
        half_t ao;
        half_t be;
        half_t bo;
    } halves_t;

    function automatic half_t split_half(input logic [OKA_N-1:0] v, input logic odd);
        half_t h;
        for (int i = 0; i < int'(OKA_H); i++) begin
            h[i] = v[2 * i + (odd ? 1 : 0)];
        end
        return h;
    endfunction

    // Index of the highest set bit; 0 when y is zero so at least one step runs
    function automatic step_t last_step(input half_t y);
        step_t r;
        r = '0;
        for (int i = 0; i < int'(OKA_H); i++) begin
            if (y[i]) r = step_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf2_serial_mac_lane.sv
// One bit-serial carry-less multiply lane: acc ^= Xh << step whenever the Y bit is set.
module gf2_serial_mac_lane
    import oka_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     step_en,
    input  half_t    xh,
    input  logic     yh_bit,
    input  step_t    step,
    output subprod_t acc
);

    subprod_t acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (step_en && yh_bit) begin
            acc_d = acc_q ^ (subprod_t'(xh) << step);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/oka_subproduct_engine_16bit.sv
// Splits two 16-bit GF(2) polynomials into even/odd halves and forms the four 8x8 sub-products serially.
// Define OKA_ZERO_SKIP_EN to end RUN after the highest set bit of Be|Bo.
module oka_subproduct_engine_16bit
    import oka_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OKA_N-1:0]  a,
    input  logic [OKA_N-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OKA_PW-1:0] p_ee,
    output logic [OKA_PW-1:0] p_eo,
    output logic [OKA_PW-1:0] p_oe,
    output logic [OKA_PW-1:0] p_oo
);

    state_t  state_q;
    step_t   step_q;
    step_t   last_q;
    halves_t ops_q;
    logic    out_valid_q;

    halves_t ops_d;
    step_t   last_d;
    logic    accept;
    logic    step_en;

    always_comb begin
        ops_d.ae = split_half(a, 1'b0);
        ops_d.ao = split_half(a, 1'b1);
        ops_d.be = split_half(b, 1'b0);
        ops_d.bo = split_half(b, 1'b1);
    end

`ifdef OKA_ZERO_SKIP_EN
    assign last_d = last_step(ops_d.be | ops_d.bo);
`else
    assign last_d = step_t'(OKA_H - 1);
`endif

    // in_ready looks through to out_ready so a DONE result can hand off to the next op in one edge
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign step_en  = (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            last_q      <= '0;
            ops_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ops_q   <= ops_d;
                        last_q  <= last_d;
                        step_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (step_q == last_q) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        step_q <= step_q + step_t'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            ops_q   <= ops_d;
                            last_q  <= last_d;
                            step_q  <= '0;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;

    gf2_serial_mac_lane u_lane_ee (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .step_en (step_en),
        .xh      (ops_q.ae),
        .yh_bit  (ops_q.be[step_q]),
        .step    (step_q),
        .acc     (p_ee)
    );

    gf2_serial_mac_lane u_lane_eo (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .step_en (step_en),
        .xh      (ops_q.ae),
        .yh_bit  (ops_q.bo[step_q]),
        .step    (step_q),
        .acc     (p_eo)
    );

    gf2_serial_mac_lane u_lane_oe (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .step_en (step_en),
        .xh      (ops_q.ao),
        .yh_bit  (ops_q.be[step_q]),
        .step    (step_q),
        .acc     (p_oe)
    );

    gf2_serial_mac_lane u_lane_oo (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .step_en (step_en),
        .xh      (ops_q.ao),
        .yh_bit  (ops_q.bo[step_q]),
        .step    (step_q),
        .acc     (p_oo)
    );

endmodule

// File: tb/tb_oka_subproduct_engine_16bit.sv
// Directed-vector and random-reference bench for oka_subproduct_engine_16bit.
module tb_oka_subproduct_engine_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] p_ee, p_eo, p_oe, p_oo;

    int checks = 0;
    int errors = 0;

    oka_subproduct_engine_16bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_ee      (p_ee),
        .p_eo      (p_eo),
        .p_oe      (p_oe),
        .p_oo      (p_oo)
    );

    always #5 clk = ~clk;

`ifdef OKA_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [14:0] ee;
        logic [14:0] eo;
        logic [14:0] oe;
        logic [14:0] oo;
        int          lat_full;
        int          lat_skip;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] clmul16(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (y[i]) r = r ^ (32'(x) << i);
        end
        return r;
    endfunction

    function automatic logic [31:0] spread(input logic [14:0] p);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 15; k++) r[2 * k] = p[k];
        return r;
    endfunction

    function automatic logic [31:0] overlap(input logic [14:0] ee, input logic [14:0] eo,
                                            input logic [14:0] oe, input logic [14:0] oo);
        return spread(ee) ^ (spread(eo ^ oe) << 1) ^ (spread(oo) << 2);
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 50) chk("done_timeout", 32'(lat), 32'(0));
    endtask

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, output int lat);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    int lat;
    logic [14:0] h_ee, h_eo, h_oe, h_oo;

    initial begin
        vecs[0] = '{16'h0001, 16'h0001, 15'h0001, 15'h0000, 15'h0000, 15'h0000, 8, 1};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 15'h5555, 15'h5555, 15'h5555, 15'h5555, 8, 8};
        vecs[2] = '{16'h0003, 16'h8000, 15'h0000, 15'h0080, 15'h0000, 15'h0080, 8, 8};
        vecs[3] = '{16'h0003, 16'h0001, 15'h0001, 15'h0000, 15'h0001, 15'h0000, 8, 1};
        vecs[4] = '{16'h0002, 16'h0002, 15'h0000, 15'h0000, 15'h0000, 15'h0001, 8, 1};
        vecs[5] = '{16'h0005, 16'h0014, 15'h000A, 15'h0000, 15'h0000, 15'h0000, 8, 3};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 'x;
        b = 'x;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_p_all", 32'({p_ee, p_eo} | {p_oe, p_oo}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_x_p_ee", 32'(p_ee), 32'(0));

        // Directed table
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(ZS ? vecs[i].lat_skip : vecs[i].lat_full));
            chk($sformatf("v%0d_p_ee", i), 32'(p_ee), 32'(vecs[i].ee));
            chk($sformatf("v%0d_p_eo", i), 32'(p_eo), 32'(vecs[i].eo));
            chk($sformatf("v%0d_p_oe", i), 32'(p_oe), 32'(vecs[i].oe));
            chk($sformatf("v%0d_p_oo", i), 32'(p_oo), 32'(vecs[i].oo));
            chk($sformatf("v%0d_in_ready_done", i), 32'(in_ready), 32'(0));
            release_result();
            chk($sformatf("v%0d_out_valid_clr", i), 32'(out_valid), 32'(0));
            chk($sformatf("v%0d_idle_hold", i), 32'(p_ee), 32'(vecs[i].ee));
        end

        // Stall in DONE for 5 cycles, then back-to-back accept
        start_op(16'hFFFF, 16'hFFFF, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("stall_out_valid", 32'(out_valid), 32'(1));
            chk("stall_in_ready", 32'(in_ready), 32'(0));
            chk("stall_p", 32'(p_ee ^ p_oo), 32'(0));
            chk("stall_p_eo", 32'(p_eo), 32'h5555);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'h0001;
        b = 16'h0001;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_out_valid_drop", 32'(out_valid), 32'(0));
        wait_done(lat);
        chk("b2b_latency", 32'(lat), 32'(ZS ? 1 : 8));
        chk("b2b_p_ee", 32'(p_ee), 32'h0001);
        chk("b2b_p_oo", 32'(p_oo), 32'h0000);
        release_result();

        // Reset asserted at RUN step 4
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'(0));
        chk("midrun_rst_in_ready", 32'(in_ready), 32'(1));
        chk("midrun_rst_p", 32'({p_ee, p_eo} | {p_oe, p_oo}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        start_op(16'h0002, 16'h0002, lat);
        chk("post_rst_latency", 32'(lat), 32'(ZS ? 1 : 8));
        chk("post_rst_p_oo", 32'(p_oo), 32'h0001);
        chk("post_rst_p_other", 32'({p_ee, p_eo, p_oe}), 32'(0));
        release_result();

        // Random operands with random downstream stalls, checked after overlap recombination
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            start_op(ra, rb, lat);
            h_ee = p_ee;
            h_eo = p_eo;
            h_oe = p_oe;
            h_oo = p_oo;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if ({h_ee, h_eo, h_oe, h_oo} !== {p_ee, p_eo, p_oe, p_oo})
                chk($sformatf("rnd%0d_stable", n), 32'(p_ee ^ p_oo), 32'(h_ee ^ h_oo));
            chk($sformatf("rnd%0d_product", n), overlap(p_ee, p_eo, p_oe, p_oo), clmul16(ra, rb));
            release_result();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
